// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//
// Program counter and return-address stack for the single-cycle CPU.  The
// registered PC drives the program-memory word address directly.  The decoder
// returns redirect requests in the same cycle, and they select the next PC.
//
// Next-PC priority when not stalled: ret > call > jump > increment.  A
// lower-priority request asserted alongside a higher one is ignored
// completely, including any stack effect it would have had.
//
// Ports
//   clk         in   system clock; all state updates on the rising edge
//   reset       in   synchronous, active-low; reinitialises pc/sp/stack_err
//   stall       in   1 = hold all state; redirect inputs are ignored
//   jump        in   absolute jump to target
//   call        in   push pc+1, then jump to target
//   ret         in   pop the return address into pc
//   target      in   jump/call destination (AW bits)
//   pc          out  current PC (registered)
//   sp          out  number of valid stack entries, 0..DEPTH
//   stack_full  out  sp == DEPTH
//   stack_empty out  sp == 0
//   stack_err   out  sticky overflow/underflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter int AW       = 10,
  parameter int DEPTH    = 8,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     jump,
  input  logic                     call,
  input  logic                     ret,
  input  logic [AW-1:0]            target,
  output logic [AW-1:0]            pc,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     stack_err
);

  localparam int IW  = $clog2(DEPTH);  // stack index width
  localparam int SPW = IW + 1;         // sp must be able to hold DEPTH itself

  // Resolved action for this cycle, after priority and stack-bound checks.
  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_INC      = 3'd1,
    OP_JUMP     = 3'd2,
    OP_PUSH     = 3'd3,
    OP_CALL_OVF = 3'd4,
    OP_POP      = 3'd5,
    OP_RET_UNF  = 3'd6
  } op_e;

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];

  op_e            op;
  logic [AW-1:0]  pc_inc;
  logic           full_w;
  logic           empty_w;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;
  logic           push_en;

  assign full_w   = (sp_q == SPW'(DEPTH));
  assign empty_w  = (sp_q == {SPW{1'b0}});
  assign pc_inc   = pc_q + AW'(1);            // wraps modulo 2^AW
  // Truncation is safe: push_idx is only used when not full and pop_idx only
  // when not empty, so both are then within 0..DEPTH-1.
  assign push_idx = IW'(sp_q);
  assign pop_idx  = IW'(sp_q - SPW'(1));

  // Resolve redirect requests into a single action.
  always_comb begin
    op = OP_HOLD;
    if (stall) begin
      op = OP_HOLD;
    end else if (ret) begin
      if (empty_w) begin
        op = OP_RET_UNF;
      end else begin
        op = OP_POP;
      end
    end else if (call) begin
      if (full_w) begin
        op = OP_CALL_OVF;
      end else begin
        op = OP_PUSH;
      end
    end else if (jump) begin
      op = OP_JUMP;
    end else begin
      op = OP_INC;
    end
  end

  // Next-state values for pc, sp and the sticky error flag.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (op)
      OP_HOLD: begin
        pc_d = pc_q;
      end
      OP_INC: begin
        pc_d = pc_inc;
      end
      OP_JUMP: begin
        pc_d = target;
      end
      OP_PUSH: begin
        pc_d    = target;
        sp_d    = sp_q + SPW'(1);
        push_en = 1'b1;
      end
      OP_CALL_OVF: begin
        // The redirect still happens; only the return address is lost.
        pc_d  = target;
        err_d = 1'b1;
      end
      OP_POP: begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_q - SPW'(1);
      end
      OP_RET_UNF: begin
        // Nothing to return to: fall through to the next instruction.
        pc_d  = pc_inc;
        err_d = 1'b1;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // PC, stack pointer and error flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= AW'(RESET_PC);
      sp_q  <= {SPW{1'b0}};
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address storage.  It is not reset, because entries above sp are
  // never read.  A push during a reset edge is suppressed so that reset always
  // leaves the stack logically empty.
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_full  = full_w;
  assign stack_empty = empty_w;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
//
// Directed scenarios, followed by a randomized run.  The randomized run is
// checked against a queue-based reference model of the PC and return stack.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

  localparam int AW    = 10;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          jump;
  logic          call;
  logic          ret;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic [3:0]    sp;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state.
  int m_pc;
  int m_stk[$];
  bit m_err;

  always #5 clk = ~clk;

  pc_fetch #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .pc          (pc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  // Behavioural model: one clock edge, using the inputs that were applied.
  task automatic model_update();
    if (!reset) begin
      m_pc = 0;
      m_stk.delete();
      m_err = 1'b0;
    end else if (!stall) begin
      if (ret) begin
        if (m_stk.size() == 0) begin
          m_pc  = (m_pc + 1) % 1024;
          m_err = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (call) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back((m_pc + 1) % 1024);
        m_pc = int'(target);
      end else if (jump) begin
        m_pc = int'(target);
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
  endtask

  // Apply inputs, clock once, update the model, and sample 1 ns after the edge.
  task automatic step(input logic s, input logic j, input logic c, input logic r,
                      input logic [AW-1:0] t);
    stall  = s;
    jump   = j;
    call   = c;
    ret    = r;
    target = t;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    idle(n);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(2);
    chk_cnt++;
    if (pc !== 10'h000) $display("FAIL reset_pc: got %h expected 000", pc);
    else pass_cnt++;
    chk_cnt++;
    if (sp !== 4'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0)
      $display("FAIL reset_flags: got sp=%0d empty=%b full=%b err=%b expected 0 1 0 0",
               sp, stack_empty, stack_full, stack_err);
    else pass_cnt++;
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      chk_cnt++;
      if (pc !== 10'(i)) $display("FAIL inc_pc: got %h expected %h", pc, 10'(i));
      else pass_cnt++;
    end
    chk_cnt++;
    if (stack_empty !== 1'b1 || stack_err !== 1'b0)
      $display("FAIL inc_flags: got empty=%b err=%b expected 1 0", stack_empty, stack_err);
    else pass_cnt++;
    idle(1018);
    chk_cnt++;
    if (pc !== 10'h3FF) $display("FAIL inc_top: got %h expected 3ff", pc);
    else pass_cnt++;
    idle(1);
    chk_cnt++;
    if (pc !== 10'h000) $display("FAIL inc_wrap: got %h expected 000", pc);
    else pass_cnt++;
  endtask

  task automatic test_jump_stall();
    apply_reset(1);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'h200);
    chk_cnt++;
    if (pc !== 10'h200) $display("FAIL jump_pc: got %h expected 200", pc);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 10'h300);
      chk_cnt++;
      if (pc !== 10'h200 || sp !== 4'd0 || stack_err !== 1'b0)
        $display("FAIL stall_hold: got pc=%h sp=%0d err=%b expected 200 0 0", pc, sp, stack_err);
      else pass_cnt++;
    end
    idle(1);
    chk_cnt++;
    if (pc !== 10'h201) $display("FAIL stall_release: got %h expected 201", pc);
    else pass_cnt++;
  endtask

  task automatic test_call_ret();
    apply_reset(1);
    idle(16);
    step(1'b0, 1'b0, 1'b1, 1'b0, 10'h100);
    chk_cnt++;
    if (pc !== 10'h100 || sp !== 4'd1 || stack_empty !== 1'b0)
      $display("FAIL call_pc: got pc=%h sp=%0d empty=%b expected 100 1 0", pc, sp, stack_empty);
    else pass_cnt++;
    idle(2);
    chk_cnt++;
    if (pc !== 10'h102) $display("FAIL call_body: got %h expected 102", pc);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    chk_cnt++;
    if (pc !== 10'h011 || sp !== 4'd0 || stack_empty !== 1'b1)
      $display("FAIL ret_pc: got pc=%h sp=%0d empty=%b expected 011 0 1", pc, sp, stack_empty);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    // The caller sits at pc=0x011.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 10'(32'h40 + i));
      if (i == 7) begin
        chk_cnt++;
        if (sp !== 4'd8 || stack_full !== 1'b1 || stack_err !== 1'b0)
          $display("FAIL ovf_full: got sp=%0d full=%b err=%b expected 8 1 0",
                   sp, stack_full, stack_err);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (pc !== 10'h048 || sp !== 4'd8 || stack_err !== 1'b1)
      $display("FAIL ovf_ninth: got pc=%h sp=%0d err=%b expected 048 8 1", pc, sp, stack_err);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] exp_pc;
      exp_pc = (i < 7) ? 10'(32'h47 - i) : 10'h012;
      step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
      chk_cnt++;
      if (pc !== exp_pc || sp !== 4'(7 - i))
        $display("FAIL ovf_unwind: got pc=%h sp=%0d expected %h %0d", pc, sp, exp_pc, 7 - i);
      else pass_cnt++;
    end
  endtask

  task automatic test_underflow_priority();
    apply_reset(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    chk_cnt++;
    if (pc !== 10'h001 || sp !== 4'd0 || stack_err !== 1'b1)
      $display("FAIL unf: got pc=%h sp=%0d err=%b expected 001 0 1", pc, sp, stack_err);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b1, 1'b0, 10'h080);
    step(1'b0, 1'b1, 1'b1, 1'b1, 10'h3FF);
    chk_cnt++;
    if (pc !== 10'h002 || sp !== 4'd0)
      $display("FAIL prio_ret: got pc=%h sp=%0d expected 002 0", pc, sp);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b1, 1'b0, 10'h155);
    chk_cnt++;
    if (pc !== 10'h155 || sp !== 4'd1)
      $display("FAIL prio_call: got pc=%h sp=%0d expected 155 1", pc, sp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 10'(32'h20 * (i + 1)));
    chk_cnt++;
    if (sp !== 4'd3 || stack_err !== 1'b1)
      $display("FAIL mid_setup: got sp=%0d err=%b expected 3 1", sp, stack_err);
    else pass_cnt++;
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 10'h123);
    reset = 1'b1;
    chk_cnt++;
    if (pc !== 10'h000 || sp !== 4'd0 || stack_err !== 1'b0 || stack_empty !== 1'b1)
      $display("FAIL mid_reset: got pc=%h sp=%0d err=%b empty=%b expected 000 0 0 1",
               pc, sp, stack_err, stack_empty);
    else pass_cnt++;
  endtask

  task automatic test_random();
    apply_reset(1);
    for (int i = 0; i < 3000; i++) begin
      logic s, j, c, r;
      // Alternate call-heavy and return-heavy phases, so that both stack
      // bounds are reached repeatedly.
      s = ($urandom % 8) == 0;
      j = ($urandom % 3) == 0;
      if ((i % 300) < 150) begin
        c = ($urandom % 2) == 0;
        r = ($urandom % 6) == 0;
      end else begin
        c = ($urandom % 6) == 0;
        r = ($urandom % 2) == 0;
      end
      reset = (($urandom % 97) != 0);
      step(s, j, c, r, 10'($urandom));
      chk_cnt++;
      if (pc !== 10'(m_pc) || sp !== 4'(m_stk.size()) || stack_err !== m_err ||
          stack_full !== (m_stk.size() == DEPTH) || stack_empty !== (m_stk.size() == 0))
        $display("FAIL rand[%0d]: got pc=%h sp=%0d err=%b full=%b empty=%b expected pc=%h sp=%0d err=%b",
                 i, pc, sp, stack_err, stack_full, stack_empty, 10'(m_pc), m_stk.size(), m_err);
      else pass_cnt++;
    end
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    jump   = 1'b0;
    call   = 1'b0;
    ret    = 1'b0;
    target = 10'h000;
    m_pc   = 0;
    m_err  = 1'b0;
    test_reset();
    test_increment();
    test_jump_stall();
    test_call_ret();
    test_overflow();
    test_underflow_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
